// File: rtl/alu_sequencer.sv
// Command sequencer for an 8-bit combinational ALU. It repeats an op by feeding
// z back into a, keeps a chaining accumulator, and returns a result on a valid/ready output.
module alu_sequencer #(
    parameter int W    = 8,
    parameter int OPW  = 3,
    parameter int CNTW = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [OPW-1:0]  cmd_op,
    input  logic [W-1:0]    cmd_a,
    input  logic [W-1:0]    cmd_b,
    input  logic            cmd_acc,
    input  logic [CNTW-1:0] cmd_rep,
    output logic [W-1:0]    alu_a,
    output logic [W-1:0]    alu_b,
    output logic [OPW-1:0]  alu_op,
    input  logic [W-1:0]    alu_z,
    input  logic            alu_ov,
    input  logic            alu_cout,
    input  logic            alu_sign,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [W-1:0]    res_z,
    output logic            res_ov,
    output logic            res_cout,
    output logic            res_sign,
    output logic [W-1:0]    acc,
    output logic            busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNTW-1:0] REP_ONE = {{(CNTW-1){1'b0}}, 1'b1};

    state_t          r_state;
    logic [W-1:0]    r_alu_a;
    logic [W-1:0]    r_alu_b;
    logic [OPW-1:0]  r_alu_op;
    logic [CNTW-1:0] r_rep;
    logic            r_ov_sticky;
    logic [W-1:0]    r_res_z;
    logic            r_res_ov;
    logic            r_res_cout;
    logic            r_res_sign;
    logic [W-1:0]    r_acc;

    // Handshake and status decode straight from the state register.
    assign cmd_ready = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign res_valid = (r_state == ST_DONE);

    assign alu_a    = r_alu_a;
    assign alu_b    = r_alu_b;
    assign alu_op   = r_alu_op;
    assign res_z    = r_res_z;
    assign res_ov   = r_res_ov;
    assign res_cout = r_res_cout;
    assign res_sign = r_res_sign;
    assign acc      = r_acc;

    // Sequencer FSM: accept, iterate passes with z fed back into a, then hold the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_op    <= '0;
            r_rep       <= '0;
            r_ov_sticky <= 1'b0;
            r_res_z     <= '0;
            r_res_ov    <= 1'b0;
            r_res_cout  <= 1'b0;
            r_res_sign  <= 1'b0;
            r_acc       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_alu_a     <= cmd_acc ? r_acc : cmd_a;
                        r_alu_b     <= cmd_b;
                        r_alu_op    <= cmd_op;
                        r_rep       <= cmd_rep;
                        r_ov_sticky <= 1'b0;
                        r_state     <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_ov_sticky <= r_ov_sticky | alu_ov;
                    if (r_rep != '0) begin
                        r_rep   <= r_rep - REP_ONE;
                        r_alu_a <= alu_z;
                    end else begin
                        // Final pass: ov is folded in here since the sticky register lags a cycle.
                        r_res_z    <= alu_z;
                        r_res_ov   <= r_ov_sticky | alu_ov;
                        r_res_cout <= alu_cout;
                        r_res_sign <= alu_sign;
                        r_acc      <= alu_z;
                        r_state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (res_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: a behavioural ALU drives the feedback path, and each
// command's result comes from a pass-by-pass arithmetic reference loop.
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic       cmd_acc;
    logic [3:0] cmd_rep;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_op;
    logic [7:0] alu_z;
    logic       alu_ov;
    logic       alu_cout;
    logic       alu_sign;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_z;
    logic       res_ov;
    logic       res_cout;
    logic       res_sign;
    logic [7:0] acc;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] m_acc;

    always #5 clk = ~clk;

    alu_sequencer #(.W(8), .OPW(3), .CNTW(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_acc(cmd_acc), .cmd_rep(cmd_rep),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_z(alu_z), .alu_ov(alu_ov), .alu_cout(alu_cout), .alu_sign(alu_sign),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_z(res_z), .res_ov(res_ov), .res_cout(res_cout), .res_sign(res_sign),
        .acc(acc), .busy(busy)
    );

    // Behavioural ALU; result packed as {ov, cout, z}.
    function automatic logic [9:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                          input logic [2:0] op);
        logic [8:0] s;
        logic [7:0] z;
        logic       c;
        logic       v;
        s = 9'd0;
        z = 8'd0;
        c = 1'b0;
        v = 1'b0;
        case (op)
            3'd0: begin
                s = {1'b0, a} + {1'b0, b};
                z = s[7:0];
                c = s[8];
                v = (a[7] == b[7]) && (z[7] != a[7]);
            end
            3'd1: begin
                s = {1'b0, a} - {1'b0, b};
                z = s[7:0];
                c = s[8];
                v = (a[7] != b[7]) && (z[7] != a[7]);
            end
            3'd2: z = a & b;
            3'd3: z = a ^ b;
            3'd4: begin
                z = {a[6:0], 1'b0};
                c = a[7];
            end
            default: z = a;
        endcase
        return {v, c, z};
    endfunction

    assign {alu_ov, alu_cout, alu_z} = alu_fn(alu_a, alu_b, alu_op);
    assign alu_sign = alu_z[7];

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Issue one command from IDLE, check every pass and the result, then drain it.
    task automatic run_cmd(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                           input logic use_acc, input logic [3:0] rep, input int hold);
        logic [7:0] a_seq [16];
        logic [7:0] pa;
        logic [9:0] r;
        logic       ovs;
        pa  = use_acc ? m_acc : a;
        ovs = 1'b0;
        r   = 10'd0;
        for (int i = 0; i <= int'(rep); i++) begin
            a_seq[i] = pa;
            r        = alu_fn(pa, b, op);
            ovs      = ovs | r[9];
            pa       = r[7:0];
        end

        chk1("cmd_ready_idle", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_a     = a;
        cmd_b     = b;
        cmd_op    = op;
        cmd_acc   = use_acc;
        cmd_rep   = rep;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_a     = 8'($urandom);
        for (int i = 0; i <= int'(rep); i++) begin
            chk8("pass_alu_a", alu_a, a_seq[i]);
            chk8("pass_alu_b", alu_b, b);
            chk1("pass_res_valid", res_valid, 1'b0);
            chk1("pass_busy", busy, 1'b1);
            @(posedge clk); #1;
        end
        chk1("res_valid_latency", res_valid, 1'b1);
        chk8("res_z", res_z, r[7:0]);
        chk1("res_ov", res_ov, ovs);
        chk1("res_cout", res_cout, r[8]);
        chk1("res_sign", res_sign, r[7]);
        chk8("acc", acc, r[7:0]);
        m_acc = r[7:0];

        for (int h = 0; h < hold; h++) begin
            cmd_valid = 1'b1;
            @(posedge clk); #1;
            chk1("bp_res_valid", res_valid, 1'b1);
            chk8("bp_res_z", res_z, r[7:0]);
            chk1("bp_cmd_ready", cmd_ready, 1'b0);
            chk8("bp_alu_a_hold", alu_a, a_seq[rep]);
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk1("drain_res_valid", res_valid, 1'b0);
        chk1("drain_busy", busy, 1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_a     = 8'd0;
        cmd_b     = 8'd0;
        cmd_acc   = 1'b0;
        cmd_rep   = 4'd0;
        res_ready = 1'b0;
        m_acc     = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk1("rst_cmd_ready", cmd_ready, 1'b1);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_res_valid", res_valid, 1'b0);
        chk8("rst_acc", acc, 8'h00);
        chk8("rst_alu_a", alu_a, 8'h00);
        chk8("rst_alu_b", alu_b, 8'h00);

        run_cmd(8'hA9, 8'h83, 3'd0, 1'b0, 4'd0, 0);
        chk8("single_add_z", res_z, 8'h2C);
        run_cmd(8'h03, 8'h05, 3'd0, 1'b0, 4'd3, 0);
        chk8("repeat_z", res_z, 8'h17);
        run_cmd(8'h69, 8'h43, 3'd0, 1'b0, 4'd1, 0);
        chk1("sticky_ov", res_ov, 1'b1);
        chk8("sticky_z", res_z, 8'hEF);
        run_cmd(8'h55, 8'h11, 3'd0, 1'b1, 4'd0, 5);
        chk8("chain_acc", acc, 8'h00);
        chk1("chain_cout", res_cout, 1'b1);
        run_cmd(8'h01, 8'h01, 3'd0, 1'b0, 4'd15, 0);
        chk8("rep_max_z", res_z, 8'h11);

        // Abort a 8-pass command with reset asserted at its third EXEC edge.
        cmd_valid = 1'b1;
        cmd_a     = 8'h10;
        cmd_b     = 8'h01;
        cmd_op    = 3'd0;
        cmd_acc   = 1'b0;
        cmd_rep   = 4'd7;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk8("abort_mid_alu_a", alu_a, 8'h12);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk1("abort_busy", busy, 1'b0);
        chk1("abort_res_valid", res_valid, 1'b0);
        chk1("abort_cmd_ready", cmd_ready, 1'b1);
        chk8("abort_acc", acc, 8'h00);
        chk8("abort_alu_a", alu_a, 8'h00);
        m_acc = 8'h00;
        @(posedge clk); #1;
        chk1("abort_stays_idle", res_valid, 1'b0);

        for (int n = 0; n < 40; n++) begin
            logic [3:0] rep;
            rep = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15))
                                              : 4'($urandom_range(0, 2));
            run_cmd(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)),
                    1'($urandom_range(0, 1)), rep, int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Command-driven controller for the 8-bit combinational ALU (a, b, op in; z, ov, cout, sign out).
- Accepts one operation per valid/ready handshake, drives the registered ALU operands and captures results.
- Can repeat an op N extra times, feeding z back into a on each pass (repeated add/shift, etc.).
- Keeps an 8-bit accumulator for chaining commands and presents the result plus flags on a valid/ready output.

Parameters:
- W, 8, datapath width (matches ALU a/b/z)
- OPW, 3, ALU op-code width
- CNTW, 4, repeat-counter width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can accept a command
- cmd_op  in  OPW  ALU op, passed through unchanged
- cmd_a  in  W  operand a (ignored when cmd_acc=1)
- cmd_b  in  W  operand b
- cmd_acc  in  1  1: use acc as first-pass a
- cmd_rep  in  CNTW  extra passes; total passes = cmd_rep+1
- alu_a  out  W  to ALU a
- alu_b  out  W  to ALU b
- alu_op  out  OPW  to ALU op
- alu_z  in  W  from ALU z
- alu_ov  in  1  from ALU ov
- alu_cout  in  1  from ALU cout
- alu_sign  in  1  from ALU sign
- res_valid  out  1  result available
- res_ready  in  1  consumer takes result
- res_z  out  W  final z
- res_ov  out  1  sticky OR of ov over all passes
- res_cout  out  1  cout of final pass
- res_sign  out  1  sign of final pass
- acc  out  W  accumulator
- busy  out  1  state != IDLE

Behaviour:
- Reset (sync, rst=1 at an edge): state=IDLE, all registered outputs 0: alu_a/b/op, res_*, acc, rep counter. cmd_ready=1 and busy=0 combinationally from IDLE. Reset mid-command aborts it; no result is produced.
- States: IDLE, EXEC, DONE.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready at an edge:
  - alu_a <= (cmd_acc ? acc : cmd_a), alu_b <= cmd_b, alu_op <= cmd_op
  - rep <= cmd_rep; clear sticky ov; go to EXEC.
- EXEC: the ALU is combinational, so alu_z and flags are valid within the cycle. At each edge in EXEC:
  - ov_sticky |= alu_ov.
  - If rep != 0: rep <= rep-1, alu_a <= alu_z, alu_b/alu_op hold; stay in EXEC.
  - If rep == 0: res_z <= alu_z, res_ov <= ov_sticky|alu_ov, res_cout <= alu_cout, res_sign <= alu_sign, acc <= alu_z; go to DONE.
- Latency: res_valid goes high exactly cmd_rep+1 cycles after the acceptance edge.
- DONE: res_valid=1; res_* stable while res_ready=0 (indefinite backpressure). On res_ready=1 at an edge go to IDLE; a new command is accepted no earlier than the following edge.
- cmd_ready=0 in EXEC and DONE; cmd_valid there is ignored and not lost (producer holds it).
- alu_a/b/op hold their last values in IDLE and DONE (no spurious ALU toggling). res_* and acc hold until overwritten by the next completed command.
- Arithmetic: no width growth; all values W bits; the controller never interprets op or flags beyond the sticky OR.
- rep=max (15) gives 16 passes; the counter does not wrap.

Test Plan:
Bench uses a behavioural ALU with op 000 = a+b (z=sum[7:0], cout=sum[8], ov=signed overflow, sign=z[7]).
- Reset: rst=1 for 2 cycles -> cmd_ready=1, busy=0, res_valid=0, acc=0x00, alu_a=alu_b=0x00.
- Single add: a=0xA9, b=0x83, op=000, rep=0 -> res_valid 1 cycle after accept; res_z=0x2C, cout=1, ov=1, sign=0; acc=0x2C.
- Repeat: a=0x03, b=0x05, rep=3 -> alu_a sequence 0x03, 0x08, 0x0D, 0x12; res_valid 4 cycles after accept; res_z=0x17, ov=0, cout=0.
- Sticky ov: a=0x69, b=0x43, rep=1 -> pass1 0xAC (ov=1), pass2 0xEF (ov=0); res_z=0xEF, res_ov=1, sign=1, cout=0.
- Chaining: after the sticky-ov test (acc=0xEF): cmd_acc=1, cmd_a=0x55 (ignored), b=0x11, rep=0 -> res_z=0x00, cout=1, ov=0, sign=0, acc=0x00.
- Backpressure and abort:
  - res_ready=0 for 5 cycles -> res_valid stays 1, res_z stable, cmd_ready=0 despite cmd_valid=1.
  - Then accept rep=7; assert rst at the 3rd EXEC edge -> next cycle IDLE, res_valid=0, acc=0x00, busy=0.
